uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Next-generation UART transmitter with a runtime-configurable frame format:
- 5–8 data bits, even/odd/no parity, 1 or 2 stop bits.
- Baud divisor is set at runtime.
- A parametrised TX FIFO is fed by a valid/ready handshake.

It sits between the host/register logic and the txd pad, replacing the single-byte fixed-baud transmitter. Frames go out back-to-back, with no idle gap, while the FIFO holds data.

Parameters:
- FIFO_DEPTH, 16, number of FIFO entries; power of 2, minimum 2.
- DIV_W, 16, width of the baud divisor input.
- DEF_DIV, 434, reference divisor for 50 MHz / 115200; used by the bench default only.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tx_data  in  8  byte to send, LSB first; bits above the configured data width are ignored
- tx_valid  in  1  producer has a byte
- tx_ready  out  1  FIFO can accept; equals !full
- tx_flush  in  1  synchronous FIFO clear; does not abort the frame in flight
- cfg_div  in  DIV_W  clocks per bit; values 0 and 1 are treated as 2
- cfg_dbits  in  2  data bits: 00=5, 01=6, 10=7, 11=8
- cfg_parity  in  2  00=even, 01=odd, 10=none, 11=none
- cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits
- txd  out  1  serial line, idle high
- tx_busy  out  1  frame in progress or FIFO non-empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: clk, with rst_n asynchronous active-low.
- Reset values: txd=1, tx_busy=0, tx_ready=1, fifo_level=0, FSM in IDLE, all counters 0. A reset mid-frame drives txd high immediately and discards the frame and the FIFO contents.
- Push: occurs on a clk edge where tx_valid && tx_ready.
- Pop: occurs when the FSM loads a byte.
  - A push and a pop in the same cycle are both performed; the level is unchanged.
  - tx_flush takes precedence over a same-cycle push: the level goes to 0 and the push is dropped.
- Config latch: cfg_* are latched into shadow registers at frame load. Changes mid-frame take effect from the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty, pop, latch data and cfg, drive txd=0 on that edge, and go to START.
  - A byte pushed into an empty FIFO on edge N gives txd low after edge N+1.
- Bit timing: a bit counter runs 0..div-1; each state holds one bit for exactly div clocks, where div = max(cfg_div, 2).
  - START → DATA, bit index 0.
  - DATA: txd = data[idx]. After bit nbits-1, go to PARITY if parity is enabled, else to STOP.
  - PARITY: txd = ^data[nbits-1:0] for even, or ~^data[nbits-1:0] for odd; only the configured bits are included. Then go to STOP.
  - STOP: txd=1 for 1 or 2 bit times. At the end of the last stop bit, if the FIFO is non-empty, pop and go straight to START with txd=0 on the same edge; otherwise go to IDLE.
- Frame length: (1 + nbits + P + S) × div clocks, where P∈{0,1} and S∈{1,2}.
- tx_busy = (state != IDLE) || (fifo_level != 0); registered or combinational, with no extra latency allowed beyond one cycle.
- Wrap-around: FIFO pointers are $clog2(FIFO_DEPTH) bits plus a wrap bit. Full means the addresses are equal and the wrap bits differ.

Decomposition:
- Package uart_pkg holds:
  - parity encodings PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_NONE=2'b10
  - data-bit encodings
  - FSM state enum
  - function dbits_to_n()
- Sub-module sync_fifo (parameters WIDTH=8, DEPTH) provides push/pop/flush, full, empty, and level; it is reused later by the receive path.
- The FSM and baud counter live in the top module.

Test Plan:
- 8N1, div=4, push 0x55 → txd low after edge N+1. Bits seen every 4 clocks are 0,1,0,1,0,1,0,1,0,1. Frame is 40 clocks, then tx_busy=0.
- 8E1 with 0x07, then 8O1 with 0x07, div=4 → parity bit is 1 for even and 0 for odd. Frame is 44 clocks each.
- 7 data bits, no parity, 2 stop bits, 0xC1 → data bits sent are 1,0,0,0,0,0,1 (bit 7 ignored), followed by 2 stop bits. Frame is 40 clocks.
- Push 3 bytes back-to-back, 8N1, div=4 → three contiguous 40-clock frames with no idle cycle; fifo_level reads 3→2→1→0.
- Hold tx_valid with txd stalled until 16 entries are queued → tx_ready=0 at level 16. A push attempted while full is dropped, and the 17th byte is not transmitted. tx_flush mid-frame → level goes to 0 and the current frame still completes.
- Assert rst_n low at bit 5 of a frame → txd=1 asynchronously, tx_busy=0, fifo_level=0. After release, a new push is sent correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared frame-format encodings, FSM states and helpers for the UART transmit path
package uart_pkg;
  localparam logic [1:0] PAR_EVEN = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_NONE = 2'b10;
  localparam logic [1:0] DB_5 = 2'b00;
  localparam logic [1:0] DB_6 = 2'b01;
  localparam logic [1:0] DB_7 = 2'b10;
  localparam logic [1:0] DB_8 = 2'b11;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic logic [3:0] dbits_to_n(input logic [1:0] d);
    return 4'd5 + {2'b00, d};
  endfunction
  function automatic logic [7:0] data_mask(input logic [1:0] d);
    return 8'hff >> (2'd3 - d);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers, flush and occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic do_push, do_pop;
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = wr_ptr == rd_ptr;
  assign level   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  // pointer update; flush wins over any same-cycle push or pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  // storage write, no reset needed since empty masks stale entries
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-fed UART transmitter with runtime frame format and baud divisor
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int DEF_DIV    = 434
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          tx_flush,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_dbits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  state_t state;
  logic [DIV_W-1:0] cnt, div_q, div_eff;
  logic [2:0] idx;
  logic stop_cnt, stop2_q, txd_q;
  logic [7:0] data_q, fifo_dout;
  logic [1:0] dbits_q, par_q;
  logic full, empty, bit_end, last_data, last_stop, load, par_bit;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_valid),
    .pop   (load),
    .flush (tx_flush),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );
  assign div_eff   = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
  assign bit_end   = cnt == div_q - 1'b1;
  assign last_data = {1'b0, idx} == dbits_to_n(dbits_q) - 4'd1;
  assign last_stop = !stop2_q || stop_cnt;
  assign load      = !empty && (state == IDLE || (state == STOP && bit_end && last_stop));
  assign par_bit   = (^data_q) ^ (par_q == PAR_ODD);
  assign tx_ready  = !full;
  assign tx_busy   = (state != IDLE) || !empty;
  assign txd       = txd_q;
  // frame sequencer: loading a byte starts the start bit on the same edge, so frames chain without gaps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      stop_cnt <= 1'b0;
      data_q   <= '0;
      dbits_q  <= DB_5;
      par_q    <= PAR_EVEN;
      stop2_q  <= 1'b0;
      div_q    <= DIV_W'(DEF_DIV);
      txd_q    <= 1'b1;
    end else if (load) begin
      state    <= START;
      cnt      <= '0;
      idx      <= '0;
      stop_cnt <= 1'b0;
      data_q   <= fifo_dout & data_mask(cfg_dbits);
      dbits_q  <= cfg_dbits;
      par_q    <= cfg_parity;
      stop2_q  <= cfg_stop2;
      div_q    <= div_eff;
      txd_q    <= 1'b0;
    end else if (state != IDLE) begin
      if (!bit_end) cnt <= cnt + 1'b1;
      else begin
        cnt <= '0;
        case (state)
          START: begin
            state <= DATA;
            idx   <= '0;
            txd_q <= data_q[0];
          end
          DATA:
            if (!last_data) begin
              idx   <= idx + 3'd1;
              txd_q <= data_q[idx + 3'd1];
            end else if (!par_q[1]) begin
              state <= PARITY;
              txd_q <= par_bit;
            end else begin
              state    <= STOP;
              stop_cnt <= 1'b0;
              txd_q    <= 1'b1;
            end
          PARITY: begin
            state    <= STOP;
            stop_cnt <= 1'b0;
            txd_q    <= 1'b1;
          end
          STOP:
            if (!last_stop) stop_cnt <= 1'b1;
            else begin
              state <= IDLE;
              txd_q <= 1'b1;
            end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed stimulus with a queue-based line model checked every cycle
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int DIV_W = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0, tx_flush = 1'b0, cfg_stop2 = 1'b0;
  logic [DIV_W-1:0] cfg_div = 16'd4;
  logic [1:0] cfg_dbits = 2'b11, cfg_parity = 2'b10;
  logic tx_ready, txd, tx_busy;
  logic [$clog2(DEPTH):0] fifo_level;
  int checks = 0, errors = 0;
  logic [7:0] mq[$];
  logic stream[$];

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W), .DEF_DIV(434)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_flush   (tx_flush),
    .cfg_div    (cfg_div),
    .cfg_dbits  (cfg_dbits),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // the line as a per-clock bit list: start, data LSB first, parity, stops, each held div clocks
  function automatic void add_frame(input logic [7:0] b);
    int n = 5 + int'(cfg_dbits);
    int d = (cfg_div < 2) ? 2 : int'(cfg_div);
    int ones = 0;
    logic bits[$];
    bits.push_back(1'b0);
    for (int k = 0; k < n; k++) begin
      bits.push_back(b[k]);
      ones += int'(b[k]);
    end
    if (cfg_parity < 2) bits.push_back(cfg_parity == 2'b00 ? (ones % 2) == 1 : (ones % 2) == 0);
    bits.push_back(1'b1);
    if (cfg_stop2) bits.push_back(1'b1);
    foreach (bits[j]) repeat (d) stream.push_back(bits[j]);
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mq.delete();
      stream.delete();
    end else begin
      int sz;
      sz = mq.size();
      if (stream.size() > 0) void'(stream.pop_front());
      if (stream.size() == 0 && sz > 0) add_frame(mq.pop_front());
      if (tx_flush) mq.delete();
      else if (tx_valid && sz < DEPTH) mq.push_back(tx_data);
    end

  always @(negedge clk) begin
    check("model_txd", txd, stream.size() > 0 ? stream[0] : 1'b1);
    check("model_busy", tx_busy, stream.size() > 0 || mq.size() > 0);
    check("model_level", fifo_level, mq.size());
    check("model_ready", tx_ready, mq.size() < DEPTH);
  end

  task automatic setcfg(input int div, input logic [1:0] db, input logic [1:0] par, input logic s2);
    cfg_div = DIV_W'(div);
    cfg_dbits = db;
    cfg_parity = par;
    cfg_stop2 = s2;
  endtask

  task automatic push1(input logic [7:0] b);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic expect_frame(input string name, input logic [15:0] bits, input int nb, input int div);
    check({name, "_pre_idle"}, txd, 1'b1);
    for (int i = 0; i < nb * div; i++) begin
      @(negedge clk);
      if (i == 0) check({name, "_start"}, txd, 1'b0);
      if (i % div == div / 2) check({name, "_bit"}, txd, bits[i / div]);
    end
    check({name, "_busy_last"}, tx_busy, 1'b1);
    @(negedge clk);
    check({name, "_idle"}, tx_busy, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_level", fifo_level, 0);
    rst_n = 1'b1;
    @(negedge clk);
    setcfg(4, 2'b11, 2'b10, 1'b0);
    push1(8'h55);
    expect_frame("8n1", 16'b1010101010, 10, 4);
    setcfg(4, 2'b11, 2'b00, 1'b0);
    push1(8'h07);
    expect_frame("8e1", 16'b11000001110, 11, 4);
    setcfg(4, 2'b11, 2'b01, 1'b0);
    push1(8'h07);
    expect_frame("8o1", 16'b10000001110, 11, 4);
    setcfg(4, 2'b10, 2'b11, 1'b1);
    push1(8'hC1);
    expect_frame("7n2", 16'b1110000010, 10, 4);
    setcfg(0, 2'b00, 2'b10, 1'b0);
    push1(8'h1A);
    expect_frame("5n1_div0", 16'b1110100, 7, 2);
    setcfg(4, 2'b11, 2'b10, 1'b0);
    tx_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tx_data = 8'(i);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("b2b_level2", fifo_level, 2);
    repeat (39) @(negedge clk);
    check("b2b_level1", fifo_level, 1);
    repeat (40) @(negedge clk);
    check("b2b_level0", fifo_level, 0);
    repeat (39) @(negedge clk);
    check("b2b_busy_last", tx_busy, 1'b1);
    @(negedge clk);
    check("b2b_idle", tx_busy, 1'b0);
    tx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tx_data = 8'(8'h80 + i);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("full_ready", tx_ready, 1'b0);
    check("full_level", fifo_level, 16);
    repeat (700) @(negedge clk);
    check("drain_busy", tx_busy, 1'b0);
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data = 8'(8'h30 + i);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    tx_flush = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'hAA;
    @(negedge clk);
    tx_flush = 1'b0;
    tx_valid = 1'b0;
    check("flush_level", fifo_level, 0);
    check("flush_busy", tx_busy, 1'b1);
    repeat (27) @(negedge clk);
    check("flush_busy_last", tx_busy, 1'b1);
    @(negedge clk);
    check("flush_idle", tx_busy, 1'b0);
    push1(8'h11);
    push1(8'h22);
    repeat (21) @(negedge clk);
    check("pre_rst_busy", tx_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_txd", txd, 1'b1);
    check("arst_busy", tx_busy, 1'b0);
    check("arst_level", fifo_level, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push1(8'h55);
    expect_frame("post_rst", 16'b1010101010, 10, 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
